// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencer state type for the ALU front end.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOTA = 3'b100;
  localparam logic [2:0] OP_NOTB = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between a requester (master) and the ALU sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int N = 4
);
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_y;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_ovf;
  logic         busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_ovf, busy
  );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: ADD/SUB/AND/OR/NOTA/NOTB over latched operands.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic         carry,
  output logic         ovf
);

  logic [N:0] sum;
  logic [N:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum[N-1:0];
        carry = sum[N];
        ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        // bit N of the widened difference is the unsigned borrow
        y     = diff[N-1:0];
        carry = diff[N];
        ovf   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOTA: y = ~a;
      OP_NOTB: y = ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU request/response sequencer: single-cycle ops via alu_comb_core, SHL and MUL
// iterated in EXEC; result held in DONE until the consumer accepts it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(N) + 1;

  state_t             state;
  logic [2:0]         op_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic [2*N-1:0]     mcand;
  logic [2*N-1:0]     acc;
  logic [2*N-1:0]     acc_next;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       sh_next;
  logic [N-1:0]       core_y;
  logic               core_carry;
  logic               core_ovf;
  logic               fin;
  logic [N-1:0]       fin_y;
  logic               fin_carry;
  logic               fin_ovf;

  alu_comb_core #(.N(N)) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y     (core_y),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  assign sh_next       = {a_q[N-2:0], 1'b0};
  assign acc_next      = acc + (b_q[0] ? mcand : '0);
  assign bus.req_ready = (state == S_IDLE) && !rst;

  // Decides whether this EXEC cycle completes the op and what gets registered.
  always_comb begin
    fin       = 1'b1;
    fin_y     = core_y;
    fin_carry = core_carry;
    fin_ovf   = core_ovf;
    case (op_q)
      OP_SHL: begin
        fin_ovf = 1'b0;
        if (cnt == '0) begin
          fin_y     = a_q;
          fin_carry = 1'b0;
        end else begin
          fin       = (cnt == CNT_W'(1));
          fin_y     = sh_next;
          fin_carry = a_q[N-1];
        end
      end
      OP_MUL: begin
        fin       = (cnt == CNT_W'(1));
        fin_y     = acc_next[N-1:0];
        fin_carry = |acc_next[2*N-1:N];
        fin_ovf   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      mcand         <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_ovf   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q     <= bus.req_op;
            a_q      <= bus.req_a;
            b_q      <= bus.req_b;
            mcand    <= {{N{1'b0}}, bus.req_a};
            acc      <= '0;
            cnt      <= (bus.req_op == OP_MUL) ? CNT_W'(N)
                                               : {1'b0, bus.req_b[CNT_W-2:0]};
            bus.busy <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_SHL && cnt != '0) begin
            a_q <= sh_next;
            cnt <= cnt - CNT_W'(1);
          end
          if (op_q == OP_MUL) begin
            acc   <= acc_next;
            mcand <= {mcand[2*N-2:0], 1'b0};
            b_q   <= {1'b0, b_q[N-1:1]};
            cnt   <= cnt - CNT_W'(1);
          end
          if (fin) begin
            bus.rsp_y     <= fin_y;
            bus.rsp_carry <= fin_carry;
            bus.rsp_zero  <= (fin_y == '0);
            bus.rsp_ovf   <= fin_ovf;
            bus.rsp_valid <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
